// File: rtl/anton_neopixel_stream_decoder_pkg.sv
// Shared types, defaults and helpers for the NeoPixel stream decoder.
// Defaults match the 7 MHz transmitter: 8-cycle bit period, '0' = 2 high,
// '1' = 6 high, so HIGH_ONE=4 sits midway and HIGH_MAX=7 leaves one
// cycle of margin before the pattern could only be a stuck line.
package anton_neopixel_stream_decoder_pkg;

  // Default buffer depth and latch gap (about 50 us at 7 MHz).
  localparam int BUFFER_END_DEFAULT  = 63;
  localparam int RESET_DELAY_DEFAULT = 350;

  // Default high-width classification thresholds in clk7mhz cycles.
  localparam int HIGH_MIN_DEFAULT = 1;
  localparam int HIGH_ONE_DEFAULT = 4;
  localparam int HIGH_MAX_DEFAULT = 7;

  // Pulse width counter and pixel word geometry.
  localparam int WIDTH_BITS = 10;
  localparam logic [WIDTH_BITS-1:0] WIDTH_MAX = '1;
  localparam int PIXEL_BITS = 24;

  // Decoder FSM encoding, shared with debug tooling through the state port.
  typedef enum logic [1:0] {
    DEC_SYNC = 2'd0,
    DEC_IDLE = 2'd1,
    DEC_HIGH = 2'd2,
    DEC_LOW  = 2'd3
  } dec_state_t;

  // Width counter step that holds at full scale instead of wrapping.
  function automatic logic [WIDTH_BITS-1:0] width_sat_inc(input logic [WIDTH_BITS-1:0] w);
    return (w == WIDTH_MAX) ? w : w + WIDTH_BITS'(1);
  endfunction

endpackage

// File: rtl/anton_neopixel_stream_decoder_if.sv
// Decoded pixel/frame bus: the decoder drives it, a buffer writer consumes it.
interface anton_neopixel_stream_decoder_if
  import anton_neopixel_stream_decoder_pkg::*;
#(
  parameter int BUFFER_BITS = 6
);
  logic [PIXEL_BITS-1:0]  pixel_data;
  logic [BUFFER_BITS-1:0] pixel_index;
  logic                   pixel_valid;
  logic                   frame_done;
  logic [BUFFER_BITS:0]   frame_pixels;

  modport master (
    output pixel_data,
    output pixel_index,
    output pixel_valid,
    output frame_done,
    output frame_pixels
  );

  modport slave (
    input pixel_data,
    input pixel_index,
    input pixel_valid,
    input frame_done,
    input frame_pixels
  );
endinterface

// File: rtl/anton_neopixel_pulse_meter.sv
// Brings the asynchronous serial line into the clk7mhz domain, flags its
// edges and measures how long the line has held its current level.
module anton_neopixel_pulse_meter
  import anton_neopixel_stream_decoder_pkg::*;
(
  input  logic                  clk7mhz,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  stream_in,
  output logic                  level,
  output logic                  rise,
  output logic                  fall,
  output logic [WIDTH_BITS-1:0] width
);

  // sync_reg[0]=s1, sync_reg[1]=s2 (first safe sample), sync_reg[2]=s3 (delayed s2).
  logic [2:0]            sync_reg;
  logic [WIDTH_BITS-1:0] width_reg;

  // Two-flop synchronizer plus one extra stage for edge detection.
  always_ff @(posedge clk7mhz or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], stream_in};
    end
  end

  assign level = sync_reg[1];
  assign rise  = sync_reg[1] & ~sync_reg[2];
  assign fall  = ~sync_reg[1] & sync_reg[2];

  // Width restarts at 1 on each edge so it reads the level's length so far;
  // clr lets the decoder discard a partially measured level.
  always_ff @(posedge clk7mhz or posedge rst) begin
    if (rst) begin
      width_reg <= '0;
    end else if (clr) begin
      width_reg <= '0;
    end else if (rise || fall) begin
      width_reg <= WIDTH_BITS'(1);
    end else begin
      width_reg <= width_sat_inc(width_reg);
    end
  end

  assign width = width_reg;

endmodule

// File: rtl/anton_neopixel_stream_decoder.sv
// NeoPixel stream receiver: classifies high pulse widths into bits,
// assembles 24-bit pixels MSB first and reports frame boundaries at the
// latch gap. RESET_DETECT must exceed 1 so a pixel completion and a frame
// end can never land on the same cycle.
module anton_neopixel_stream_decoder
  import anton_neopixel_stream_decoder_pkg::*;
#(
  parameter int BUFFER_END   = BUFFER_END_DEFAULT,
  parameter int RESET_DETECT = RESET_DELAY_DEFAULT,
  parameter int HIGH_MIN     = HIGH_MIN_DEFAULT,
  parameter int HIGH_ONE     = HIGH_ONE_DEFAULT,
  parameter int HIGH_MAX     = HIGH_MAX_DEFAULT
) (
  input  logic                           clk7mhz,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           stream_in,
  anton_neopixel_stream_decoder_if.master px,
  output logic                           err_glitch,
  output logic                           err_partial,
  output logic                           err_overflow,
  output logic [1:0]                     state
);

  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1);
  localparam int PIX_BITS    = BUFFER_BITS + 1;

  localparam logic [WIDTH_BITS-1:0]  RESET_W      = WIDTH_BITS'(RESET_DETECT);
  localparam logic [WIDTH_BITS-1:0]  HIGH_MIN_W   = WIDTH_BITS'(HIGH_MIN);
  localparam logic [WIDTH_BITS-1:0]  HIGH_ONE_W   = WIDTH_BITS'(HIGH_ONE);
  localparam logic [WIDTH_BITS-1:0]  HIGH_MAX_W   = WIDTH_BITS'(HIGH_MAX);
  localparam logic [WIDTH_BITS-1:0]  HIGH_STUCK_W = WIDTH_BITS'(HIGH_MAX + 1);
  localparam logic [PIX_BITS-1:0]    BUF_END_P    = PIX_BITS'(BUFFER_END);
  localparam logic [BUFFER_BITS-1:0] BUF_END_IDX  = BUFFER_BITS'(BUFFER_END);
  localparam logic [PIX_BITS-1:0]    PIX_MAX      = '1;
  localparam logic [4:0]             LAST_BIT     = 5'd23;

  logic                  level;
  logic                  rise;
  logic                  fall;
  logic [WIDTH_BITS-1:0] width;

  dec_state_t             state_reg;
  logic [PIXEL_BITS-1:0]  shift_reg;
  logic [4:0]             bit_cnt_reg;
  logic [PIX_BITS-1:0]    pix_cnt_reg;
  logic [PIXEL_BITS-1:0]  pixel_data_reg;
  logic [BUFFER_BITS-1:0] pixel_index_reg;
  logic                   pixel_valid_reg;
  logic                   frame_done_reg;
  logic [PIX_BITS-1:0]    frame_pixels_reg;
  logic                   err_glitch_reg;
  logic                   err_partial_reg;
  logic                   err_overflow_reg;

  logic                  bit_in;
  logic                  pulse_bad;
  logic [PIXEL_BITS-1:0] shift_word;

  anton_neopixel_pulse_meter u_meter (
    .clk7mhz   (clk7mhz),
    .rst       (rst),
    .clr       (~enable),
    .stream_in (stream_in),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .width     (width)
  );

  // Classify the high pulse that is ending this cycle and form the next shift word.
  always_comb begin
    bit_in     = (width >= HIGH_ONE_W);
    pulse_bad  = (width < HIGH_MIN_W) || (width > HIGH_MAX_W);
    shift_word = {shift_reg[PIXEL_BITS-2:0], bit_in};
  end

  // Decoder FSM with pixel assembly, frame accounting and registered outputs.
  always_ff @(posedge clk7mhz or posedge rst) begin
    if (rst) begin
      state_reg        <= DEC_SYNC;
      shift_reg        <= '0;
      bit_cnt_reg      <= '0;
      pix_cnt_reg      <= '0;
      pixel_data_reg   <= '0;
      pixel_index_reg  <= '0;
      pixel_valid_reg  <= 1'b0;
      frame_done_reg   <= 1'b0;
      frame_pixels_reg <= '0;
      err_glitch_reg   <= 1'b0;
      err_partial_reg  <= 1'b0;
      err_overflow_reg <= 1'b0;
    end else begin
      pixel_valid_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      err_glitch_reg  <= 1'b0;
      err_partial_reg <= 1'b0;

      if (!enable) begin
        // Disabled: drop any partial frame silently and resynchronise later.
        state_reg        <= DEC_SYNC;
        shift_reg        <= '0;
        bit_cnt_reg      <= '0;
        pix_cnt_reg      <= '0;
        err_overflow_reg <= 1'b0;
      end else begin
        case (state_reg)
          DEC_SYNC: begin
            // Only a full latch gap guarantees we are aligned to a frame start.
            if (!level && (width >= RESET_W)) begin
              state_reg <= DEC_IDLE;
            end
          end

          DEC_IDLE: begin
            if (rise) begin
              state_reg <= DEC_HIGH;
            end
          end

          DEC_HIGH: begin
            if (fall) begin
              if (pulse_bad) begin
                err_glitch_reg <= 1'b1;
                shift_reg      <= '0;
                bit_cnt_reg    <= '0;
                pix_cnt_reg    <= '0;
                state_reg      <= DEC_SYNC;
              end else begin
                state_reg <= DEC_LOW;
                if (bit_cnt_reg == LAST_BIT) begin
                  bit_cnt_reg <= '0;
                  shift_reg   <= '0;
                  if (pix_cnt_reg > BUF_END_P) begin
                    // Past the buffer: flag it and keep the index pinned at the end.
                    err_overflow_reg <= 1'b1;
                    pixel_index_reg  <= BUF_END_IDX;
                  end else begin
                    pixel_data_reg  <= shift_word;
                    pixel_index_reg <= pix_cnt_reg[BUFFER_BITS-1:0];
                    pixel_valid_reg <= 1'b1;
                  end
                  if (pix_cnt_reg != PIX_MAX) begin
                    pix_cnt_reg <= pix_cnt_reg + PIX_BITS'(1);
                  end
                end else begin
                  bit_cnt_reg <= bit_cnt_reg + 5'd1;
                  shift_reg   <= shift_word;
                end
              end
            end else if (width >= HIGH_STUCK_W) begin
              // Line held high too long to be any legal bit pattern.
              err_glitch_reg <= 1'b1;
              shift_reg      <= '0;
              bit_cnt_reg    <= '0;
              pix_cnt_reg    <= '0;
              state_reg      <= DEC_SYNC;
            end
          end

          DEC_LOW: begin
            if (rise) begin
              state_reg <= DEC_HIGH;
            end else if (width >= RESET_W) begin
              frame_done_reg   <= 1'b1;
              frame_pixels_reg <= pix_cnt_reg;
              err_partial_reg  <= (bit_cnt_reg != 5'd0);
              shift_reg        <= '0;
              bit_cnt_reg      <= '0;
              pix_cnt_reg      <= '0;
              state_reg        <= DEC_IDLE;
            end
          end

          default: state_reg <= DEC_SYNC;
        endcase
      end
    end
  end

  assign px.pixel_data   = pixel_data_reg;
  assign px.pixel_index  = pixel_index_reg;
  assign px.pixel_valid  = pixel_valid_reg;
  assign px.frame_done   = frame_done_reg;
  assign px.frame_pixels = frame_pixels_reg;
  assign err_glitch      = err_glitch_reg;
  assign err_partial     = err_partial_reg;
  assign err_overflow    = err_overflow_reg;
  assign state           = state_reg;

endmodule

// File: tb/tb_anton_neopixel_stream_decoder.sv
// Directed bench for the NeoPixel stream decoder: drives transmitter-shaped
// bit patterns and checks pixels, frame reports and error pulses.
module tb_anton_neopixel_stream_decoder;

  localparam int BE = 3;
  localparam int RD = 40;
  localparam int BB = 2;

  logic       clk7mhz   = 1'b0;
  logic       rst       = 1'b1;
  logic       enable    = 1'b1;
  logic       stream_in = 1'b0;
  logic       err_glitch;
  logic       err_partial;
  logic       err_overflow;
  logic [1:0] state;

  anton_neopixel_stream_decoder_if #(.BUFFER_BITS(BB)) px ();

  anton_neopixel_stream_decoder #(
    .BUFFER_END   (BE),
    .RESET_DETECT (RD),
    .HIGH_MIN     (1),
    .HIGH_ONE     (4),
    .HIGH_MAX     (7)
  ) u_dut (
    .clk7mhz      (clk7mhz),
    .rst          (rst),
    .enable       (enable),
    .stream_in    (stream_in),
    .px           (px),
    .err_glitch   (err_glitch),
    .err_partial  (err_partial),
    .err_overflow (err_overflow),
    .state        (state)
  );

  always #71 clk7mhz = ~clk7mhz;

  int n_vec = 0;
  int n_err = 0;

  logic [23:0] data_q[$];
  int          idx_q[$];
  int          frm_q[$];
  int          glitch_cnt  = 0;
  int          partial_cnt = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Record decoder events, one printed line per transaction.
  always @(negedge clk7mhz) begin
    if (!rst) begin
      if (px.pixel_valid) begin
        data_q.push_back(px.pixel_data);
        idx_q.push_back(int'(px.pixel_index));
        $display("pixel  idx=%0d data=%06h", px.pixel_index, px.pixel_data);
      end
      if (px.frame_done) begin
        frm_q.push_back(int'(px.frame_pixels));
        $display("frame  pixels=%0d partial=%0b", px.frame_pixels, err_partial);
      end
      if (err_glitch) begin
        glitch_cnt++;
        $display("glitch state=%0d", state);
      end
      if (err_partial) partial_cnt++;
    end
  end

  task automatic clear_log();
    data_q.delete();
    idx_q.delete();
    frm_q.delete();
    glitch_cnt  = 0;
    partial_cnt = 0;
  endtask

  task automatic idle_low(input int n);
    stream_in = 1'b0;
    repeat (n) @(negedge clk7mhz);
  endtask

  // '1' = 6 high + 2 low, '0' = 2 high + 6 low.
  task automatic send_bit(input logic b);
    stream_in = 1'b1;
    repeat (b ? 6 : 2) @(negedge clk7mhz);
    stream_in = 1'b0;
    repeat (b ? 2 : 6) @(negedge clk7mhz);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  task automatic send_pixel(input logic [23:0] w);
    send_bits(w, 24);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk7mhz);
    expect_eq("rst_data",    32'(px.pixel_data), 32'h0);
    expect_eq("rst_valid",   32'(px.pixel_valid), 32'h0);
    expect_eq("rst_frame",   32'(px.frame_done), 32'h0);
    expect_eq("rst_ovf",     32'(err_overflow), 32'h0);
    expect_eq("rst_state",   32'(state), 32'h0);
    rst = 1'b0;
    idle_low(50);
    expect_eq("sync_to_idle", 32'(state), 32'h1);

    // Single pixel
    clear_log();
    send_pixel(24'hA5C30F);
    idle_low(50);
    expect_eq("p1_count", 32'(data_q.size()), 32'd1);
    if (data_q.size() == 1) begin
      expect_eq("p1_data", 32'(data_q[0]), 32'hA5C30F);
      expect_eq("p1_idx",  32'(idx_q[0]), 32'd0);
    end
    expect_eq("p1_frames", 32'(frm_q.size()), 32'd1);
    if (frm_q.size() == 1) expect_eq("p1_frame_pixels", 32'(frm_q[0]), 32'd1);
    expect_eq("p1_partial", 32'(partial_cnt), 32'd0);
    expect_eq("p1_state",   32'(state), 32'h1);

    // Overflow: five pixels into a four-entry buffer
    clear_log();
    for (int p = 1; p <= 5; p++) send_pixel(24'(p));
    idle_low(50);
    expect_eq("ovf_count", 32'(data_q.size()), 32'd4);
    for (int p = 0; p < 4 && p < data_q.size(); p++) begin
      expect_eq("ovf_data", 32'(data_q[p]), 32'(p + 1));
      expect_eq("ovf_idx",  32'(idx_q[p]), 32'(p));
    end
    expect_eq("ovf_flag",   32'(err_overflow), 32'h1);
    expect_eq("ovf_sat_idx", 32'(px.pixel_index), 32'd3);
    expect_eq("ovf_frames", 32'(frm_q.size()), 32'd1);
    if (frm_q.size() == 1) expect_eq("ovf_frame_pixels", 32'(frm_q[0]), 32'd5);
    enable = 1'b0;
    repeat (2) @(negedge clk7mhz);
    expect_eq("ovf_clear", 32'(err_overflow), 32'h0);
    expect_eq("dis_state", 32'(state), 32'h0);
    enable = 1'b1;
    idle_low(50);
    expect_eq("reen_state", 32'(state), 32'h1);

    // Partial frame then a clean pixel
    clear_log();
    send_bits(24'hFFC000, 10);
    idle_low(50);
    expect_eq("part_pix",     32'(data_q.size()), 32'd0);
    expect_eq("part_err",     32'(partial_cnt), 32'd1);
    expect_eq("part_frames",  32'(frm_q.size()), 32'd1);
    if (frm_q.size() == 1) expect_eq("part_frame_pixels", 32'(frm_q[0]), 32'd0);
    clear_log();
    send_pixel(24'h00BEEF);
    idle_low(50);
    expect_eq("part_next_count", 32'(data_q.size()), 32'd1);
    if (data_q.size() == 1) begin
      expect_eq("part_next_data", 32'(data_q[0]), 32'h00BEEF);
      expect_eq("part_next_idx",  32'(idx_q[0]), 32'd0);
    end
    expect_eq("part_next_partial", 32'(partial_cnt), 32'd0);

    // Stuck-high glitch mid pixel
    clear_log();
    send_bits(24'hAAAAAA, 5);
    stream_in = 1'b1;
    repeat (9) @(negedge clk7mhz);
    stream_in = 1'b0;
    repeat (4) @(negedge clk7mhz);
    expect_eq("gl_count", 32'(glitch_cnt), 32'd1);
    expect_eq("gl_state", 32'(state), 32'h0);
    send_pixel(24'h111111);
    idle_low(50);
    expect_eq("gl_ignored_pix",   32'(data_q.size()), 32'd0);
    expect_eq("gl_ignored_frame", 32'(frm_q.size()), 32'd0);
    send_pixel(24'h654321);
    idle_low(50);
    expect_eq("gl_next_count", 32'(data_q.size()), 32'd1);
    if (data_q.size() == 1) expect_eq("gl_next_data", 32'(data_q[0]), 32'h654321);
    expect_eq("gl_next_frames", 32'(frm_q.size()), 32'd1);

    // Asynchronous reset mid bit 12
    clear_log();
    send_bits(24'hFFFFFF, 11);
    stream_in = 1'b1;
    repeat (2) @(negedge clk7mhz);
    #10 rst = 1'b1;
    #1;
    expect_eq("arst_data",  32'(px.pixel_data), 32'h0);
    expect_eq("arst_idx",   32'(px.pixel_index), 32'h0);
    expect_eq("arst_state", 32'(state), 32'h0);
    @(negedge clk7mhz);
    rst = 1'b0;
    idle_low(50);
    send_pixel(24'h123456);
    idle_low(50);
    expect_eq("arst_count", 32'(data_q.size()), 32'd1);
    if (data_q.size() == 1) begin
      expect_eq("arst_next_data", 32'(data_q[0]), 32'h123456);
      expect_eq("arst_next_idx",  32'(idx_q[0]), 32'd0);
    end
    expect_eq("arst_glitch", 32'(glitch_cnt), 32'd0);

    // Enable dropped mid frame, re-enabled with the line high
    clear_log();
    send_bits(24'h5A5A5A, 8);
    enable = 1'b0;
    send_bits(24'h5A5A5A, 16);
    idle_low(50);
    expect_eq("en_off_pix",   32'(data_q.size()), 32'd0);
    expect_eq("en_off_frame", 32'(frm_q.size()), 32'd0);
    stream_in = 1'b1;
    repeat (2) @(negedge clk7mhz);
    enable = 1'b1;
    repeat (3) @(negedge clk7mhz);
    send_pixel(24'h0F0F0F);
    repeat (4) @(negedge clk7mhz);
    expect_eq("en_hold_pix",   32'(data_q.size()), 32'd0);
    expect_eq("en_hold_state", 32'(state), 32'h0);
    idle_low(50);
    send_pixel(24'hC0FFEE);
    idle_low(50);
    expect_eq("en_next_count", 32'(data_q.size()), 32'd1);
    if (data_q.size() == 1) expect_eq("en_next_data", 32'(data_q[0]), 32'hC0FFEE);
    expect_eq("en_next_frames", 32'(frm_q.size()), 32'd1);
    if (frm_q.size() == 1) expect_eq("en_next_frame_pixels", 32'(frm_q[0]), 32'd1);
    expect_eq("en_glitch", 32'(glitch_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/anton_neopixel_stream_decoder.md
Name: anton_neopixel_stream_decoder

Overview:
Receiver for the single-wire NeoPixel (WS2812-style) stream produced by the 7 MHz stream transmitter. It measures high and low pulse widths on the serial line and recovers 24-bit pixels, MSB first. It also detects the reset/latch gap and reports frame boundaries with pixel counts. It is used for loopback self-test, and for capturing a downstream chain's output into a buffer at `BUFFER_END`-indexed addresses.

Parameters:
BUFFER_END, `BUFFER_END_DEFAULT, last valid pixel index; pixel_index saturates here.
RESET_DETECT, `RESET_DELAY_DEFAULT, number of consecutive low cycles that ends a frame (latch).
HIGH_MIN, 1, minimum legal high width in cycles; shorter is a glitch.
HIGH_ONE, 4, high width >= HIGH_ONE decodes as '1'; below it decodes as '0'.
HIGH_MAX, 7, maximum legal high width; longer is a stuck-high error.
BUFFER_BITS, derived, `CLOG2(BUFFER_END+1), localparam.

Ports:
clk7mhz  in  1  7 MHz system clock; also the bit-pattern sampling clock.
rst  in  1  asynchronous active-high reset.
enable  in  1  when low, the decoder is forced to SYNC and all counters are cleared.
stream_in  in  1  serial NeoPixel line; asynchronous to the clock.
pixel_data  out  24  last decoded pixel, in wire order (first bit received = bit 23).
pixel_index  out  BUFFER_BITS  index of the pixel in pixel_data within the current frame.
pixel_valid  out  1  one-cycle pulse when pixel_data/pixel_index update.
frame_done  out  1  one-cycle pulse when the latch gap is detected after at least one bit.
frame_pixels  out  BUFFER_BITS+1  number of complete pixels in the finished frame; valid with frame_done.
err_glitch  out  1  one-cycle pulse on a high pulse shorter than HIGH_MIN or longer than HIGH_MAX.
err_partial  out  1  one-cycle pulse when a frame ends with 1-23 bits of a pixel pending.
err_overflow  out  1  sticky; set when a pixel arrives after index BUFFER_END; cleared by rst or enable low.
state  out  2  current FSM state, for debug.

Behaviour:
- Reset values: all outputs 0; synchronizer flops 0; state = SYNC.
- Input: 2-flop synchronizer (s1, s2) plus a delayed copy s3. rise = s2 & ~s3; fall = ~s2 & s3.
- Counters:
  - width_cnt: 10 bits, saturating at 1023, cleared on every edge.
  - bit_cnt: 0-23.
  - shift register: 24 bits.
  - pix_cnt: BUFFER_BITS+1 bits.
- FSM encoding is shared (see Decomposition): SYNC=0, IDLE=1, HIGH=2, LOW=3.
  - SYNC: wait until s2 has been low for RESET_DETECT consecutive cycles -> IDLE. No outputs. A high resets the wait.
  - IDLE: on rise -> HIGH; width_cnt = 1.
  - HIGH: width_cnt++ while s2 high. On fall, classify the width:
    - < HIGH_MIN: pulse err_glitch, clear shift/bit_cnt/pix_cnt, -> SYNC.
    - otherwise shift in (width >= HIGH_ONE) and -> LOW.
    - If width reaches HIGH_MAX+1 while still high: pulse err_glitch, -> SYNC.
  - LOW: width_cnt++ while s2 low. On rise -> HIGH. When width_cnt == RESET_DETECT -> frame end, -> IDLE.
- Pixel completion: on the 24th shifted bit, drive pixel_data with the completed shift word and pixel_index with pix_cnt[BUFFER_BITS-1:0], and pulse pixel_valid.
  - If pix_cnt > BUFFER_END: set err_overflow, suppress pixel_valid, saturate pixel_index at BUFFER_END; pix_cnt still increments, saturating at max.
  - bit_cnt wraps to 0.
- Latency: pixel_valid asserts on the 3rd clk7mhz rising edge after the first edge that samples stream_in low at the end of the 24th bit (2 sync + 1 registered output).
- Frame end:
  - Pulse frame_done with frame_pixels = pix_cnt.
  - If bit_cnt != 0, also pulse err_partial and discard the partial bits.
  - Clear pix_cnt, bit_cnt and shift.
  - A gap with zero bits received (IDLE staying low) emits nothing.
- Simultaneity: pixel completion and frame end cannot coincide because frame end requires RESET_DETECT low cycles, and RESET_DETECT > 1 is required. An edge on the same cycle width_cnt hits a threshold takes priority as the edge.
- enable low or rst mid-frame: immediate return to SYNC with all counters cleared and no pulses emitted. The first frame after release is only decoded after a full latch gap.

Decomposition:
- anton_common.vh gains:
  - ENUM_DEC_SYNC/IDLE/HIGH/LOW state defines;
  - default HIGH_MIN/HIGH_ONE/HIGH_MAX values matched to the transmitter's 8-cycle bit patterns.
- Sub-module anton_neopixel_pulse_meter: synchronizer, edge detect and saturating width counter. It outputs rise, fall and width.
- The FSM, shift register and counting stay in the top module.

Test Plan:
- Test settings: RESET_DETECT=40 and BUFFER_END=3 for all scenarios. Stimulus: 24 bits of 0xA5C30F (high 6 cycles for '1', 2 for '0', 8-cycle bit period), then 40 low cycles -> one pixel_valid with pixel_data=0xA5C30F, pixel_index=0; then frame_done with frame_pixels=1.
- 5 pixels 0x000001..0x000005 -> pixel_valid for indices 0-3; the 5th is suppressed and err_overflow=1; frame_done frame_pixels=5.
- 10 bits then a 40-cycle gap -> err_partial and frame_done (frame_pixels=0), no pixel_valid; the next full pixel decodes at index 0.
- A 9-cycle high mid-pixel -> err_glitch at cycle 8 of the high, FSM in SYNC; the following pixel is ignored until a 40-cycle low gap, then decodes.
- rst asserted asynchronously mid-bit 12 -> all outputs 0 immediately, state=SYNC; after release plus a 40-cycle gap, pixel 0x123456 decodes correctly.
- enable=0 during a frame -> no pulses; re-enable with the line high -> no decode until line low for 40 cycles.
